// File: rtl/sqrt_seq_ctrl_if.sv
// rtl/sqrt_seq_ctrl_if.sv - host and datapath signal bundle for the sqrt sequencing controller
//
// Host side:     start, data_in (to controller); busy, done, root, rem (from controller)
// Datapath side: D, load, excounter, ctrl, dp_clr_n (to datapath); q_in, rem_in (from datapath)
// master: controller view.  slave: view of the host/datapath surrounding the controller.

interface sqrt_seq_ctrl_if #(
    parameter int DW = 16
);
    logic          start;
    logic [DW-1:0] data_in;
    logic          busy;
    logic          done;
    logic [DW-1:0] root;
    logic [DW-1:0] rem;

    logic [DW-1:0] D;
    logic          load;
    logic [DW-1:0] excounter;
    logic          ctrl;
    logic          dp_clr_n;
    logic [DW-1:0] q_in;
    logic [DW-1:0] rem_in;

    modport master (
        input  start, data_in, q_in, rem_in,
        output busy, done, root, rem, D, load, excounter, ctrl, dp_clr_n
    );

    modport slave (
        output start, data_in, q_in, rem_in,
        input  busy, done, root, rem, D, load, excounter, ctrl, dp_clr_n
    );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - sequencer driving an iterative non-restoring square-root datapath
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    sqrt_seq_ctrl_if.master: start/data_in accepted in IDLE; D/load/excounter/ctrl/dp_clr_n
//          drive the datapath; q_in/rem_in are captured into root/rem; busy and a one-cycle done.
// Sequence after accept: CLEAR (1) -> ITER (DW/2) -> CORRECT (1) -> CAPTURE (1) -> DONE (1) -> IDLE.

module sqrt_seq_ctrl #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            reset,
    sqrt_seq_ctrl_if.master bus
);
    localparam int ITER = DW / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ITER,
        S_CORRECT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            load_nxt;
    logic            ctrl_nxt;
    logic            dp_clr_n_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic [DW-1:0]   excounter_nxt;

    // Outputs are decoded from the next state and registered, so each output
    // reflects the state the FSM occupies during that same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_nxt   = CW'(ITER - 1);
                state_nxt = S_ITER;
            end
            S_ITER: begin
                // Counter parks at zero; the last iteration hands over to CORRECT.
                if (cnt == '0) state_nxt = S_CORRECT;
                else           cnt_nxt   = cnt - CW'(1);
            end
            S_CORRECT: state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        load_nxt      = !((state_nxt == S_ITER) || (state_nxt == S_CORRECT));
        ctrl_nxt      = (state_nxt == S_CORRECT);
        dp_clr_n_nxt  = (state_nxt != S_CLEAR);
        busy_nxt      = (state_nxt != S_IDLE);
        done_nxt      = (state_nxt == S_DONE);
        excounter_nxt = (state_nxt == S_ITER) ? {{(DW-CW){1'b0}}, cnt_nxt} : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bus.load      <= 1'b1;
            bus.dp_clr_n  <= 1'b1;
            bus.ctrl      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.excounter <= '0;
            bus.D         <= '0;
            bus.root      <= '0;
            bus.rem       <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bus.load      <= load_nxt;
            bus.dp_clr_n  <= dp_clr_n_nxt;
            bus.ctrl      <= ctrl_nxt;
            bus.busy      <= busy_nxt;
            bus.done      <= done_nxt;
            bus.excounter <= excounter_nxt;
            if ((state == S_IDLE) && bus.start) bus.D <= bus.data_in;
            // Datapath has finished its correction step by the CAPTURE cycle.
            if (state == S_CAPTURE) begin
                bus.root <= bus.q_in;
                bus.rem  <= bus.rem_in;
            end
        end
    end
endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// tb/tb_sqrt_seq_ctrl.sv - directed self-checking bench for sqrt_seq_ctrl

module tb_sqrt_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sqrt_seq_ctrl_if #(.DW(16)) bus ();

    sqrt_seq_ctrl #(.DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural non-restoring square-root datapath, or a fixed stub.
    int          dp_r = 0;
    int          dp_q = 0;
    logic        use_stub = 1'b0;
    logic [15:0] stub_q = '0;
    logic [15:0] stub_r = '0;

    assign bus.q_in   = use_stub ? stub_q : dp_q[15:0];
    assign bus.rem_in = use_stub ? stub_r : dp_r[15:0];

    always @(posedge clk) begin
        int nr;
        int bits;
        if (!bus.dp_clr_n) begin
            dp_r <= 0;
            dp_q <= 0;
        end else if (!bus.load) begin
            if (bus.ctrl) begin
                if (dp_r < 0) dp_r <= dp_r + ((dp_q << 1) | 1);
            end else begin
                bits = (int'(bus.D) >> (2 * int'(bus.excounter))) & 3;
                if (dp_r >= 0) nr = (dp_r <<< 2) + bits - ((dp_q << 2) | 1);
                else           nr = (dp_r <<< 2) + bits + ((dp_q << 2) | 3);
                dp_r <= nr;
                dp_q <= (dp_q << 1) | ((nr >= 0) ? 1 : 0);
            end
        end
    end

    task automatic accept(input logic [15:0] d);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
        @(posedge clk);
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = 16'd144;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.load, bus.dp_clr_n, bus.busy, bus.done, bus.ctrl} !== 5'b11000) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b expected 11000", {bus.load, bus.dp_clr_n, bus.busy, bus.done, bus.ctrl});
            end
            vectors++;
            if ({bus.excounter, bus.D, bus.root, bus.rem} !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_data: got %h expected 0", {bus.excounter, bus.D, bus.root, bus.rem});
            end
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if ({bus.busy, bus.dp_clr_n} !== 2'b10 || bus.D !== 16'd144) begin
            miscompares++;
            $display("FAIL reset_first_accept: got busy/clr_n %b D %0d expected 10 144", {bus.busy, bus.dp_clr_n}, bus.D);
        end
        for (int i = 0; i < 30 && (bus.busy || bus.done); i++) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drain: busy %b expected 0", bus.busy);
        end
    endtask

    task automatic test_single;
        logic exp_load, exp_clr_n, exp_ctrl, exp_done, exp_busy;
        logic [15:0] exp_ec;
        accept(16'd144);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp_clr_n = (c != 1);
            exp_load  = !(c >= 2 && c <= 10);
            exp_ctrl  = (c == 10);
            exp_done  = (c == 12);
            exp_busy  = (c <= 12);
            exp_ec    = (c >= 2 && c <= 9) ? 16'(9 - c) : 16'd0;
            vectors++;
            if ({bus.load, bus.dp_clr_n, bus.ctrl, bus.done, bus.busy} !== {exp_load, exp_clr_n, exp_ctrl, exp_done, exp_busy}) begin
                miscompares++;
                $display("FAIL single_ctrl c%0d: got %b expected %b", c,
                         {bus.load, bus.dp_clr_n, bus.ctrl, bus.done, bus.busy},
                         {exp_load, exp_clr_n, exp_ctrl, exp_done, exp_busy});
            end
            vectors++;
            if (bus.excounter !== exp_ec) begin
                miscompares++;
                $display("FAIL single_excounter c%0d: got %0d expected %0d", c, bus.excounter, exp_ec);
            end
            if (c == 12) begin
                vectors++;
                if (bus.root !== 16'd12 || bus.rem !== 16'd0) begin
                    miscompares++;
                    $display("FAIL single_result: got root %0d rem %0d expected 12 0", bus.root, bus.rem);
                end
            end
        end
    endtask

    task automatic test_start_while_busy;
        int ndone = 0;
        accept(16'd144);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 5) begin bus.start = 1'b1; bus.data_in = 16'd50; end
            if (c == 6) begin bus.start = 1'b0; bus.data_in = 16'd0; end
            vectors++;
            if (bus.D !== 16'd144) begin
                miscompares++;
                $display("FAIL busy_D c%0d: got %0d expected 144", c, bus.D);
            end
            vectors++;
            if (bus.done !== (c == 12)) begin
                miscompares++;
                $display("FAIL busy_done c%0d: got %b expected %b", c, bus.done, (c == 12));
            end
            if (bus.done) ndone++;
        end
        vectors++;
        if (ndone != 1) begin
            miscompares++;
            $display("FAIL busy_done_count: got %0d expected 1", ndone);
        end
    endtask

    task automatic test_reset_mid;
        int got = 0;
        accept(16'd144);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.load, bus.dp_clr_n, bus.ctrl} !== 5'b00110 || bus.root !== 16'd0 || bus.rem !== 16'd0 || bus.excounter !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_state: got ctrl %b root %0d rem %0d ec %0d expected 00110 0 0 0",
                     {bus.busy, bus.done, bus.load, bus.dp_clr_n, bus.ctrl}, bus.root, bus.rem, bus.excounter);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) got++;
        end
        vectors++;
        if (got != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", got);
        end
        accept(16'd25);
        got = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done && got == 0) got = c;
            if (c == 12) begin
                vectors++;
                if (bus.root !== 16'd5 || bus.rem !== 16'd0) begin
                    miscompares++;
                    $display("FAIL midreset_result: got root %0d rem %0d expected 5 0", bus.root, bus.rem);
                end
            end
        end
        vectors++;
        if (got != 12) begin
            miscompares++;
            $display("FAIL midreset_latency: got %0d expected 12", got);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_done;
        accept(16'hFFFF);
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c == 38) bus.start = 1'b0;
            exp_done = (c == 12) || (c == 25) || (c == 38);
            vectors++;
            if (bus.done !== exp_done) begin
                miscompares++;
                $display("FAIL b2b_done c%0d: got %b expected %b", c, bus.done, exp_done);
            end
            if (exp_done) begin
                vectors++;
                if (bus.root !== 16'd255 || bus.rem !== 16'd510) begin
                    miscompares++;
                    $display("FAIL b2b_result c%0d: got root %0d rem %0d expected 255 510", c, bus.root, bus.rem);
                end
            end
        end
    endtask

    task automatic test_capture_isolation;
        use_stub = 1'b1;
        stub_q   = 16'hA5A5;
        stub_r   = 16'h1234;
        accept(16'd9);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c >= 12) begin
                vectors++;
                if (bus.root !== 16'hA5A5 || bus.rem !== 16'h1234) begin
                    miscompares++;
                    $display("FAIL capture_hold c%0d: got %h %h expected a5a5 1234", c, bus.root, bus.rem);
                end
            end
            if (c == 12) begin
                stub_q = 16'h0000;
                stub_r = 16'hFFFF;
            end
        end
        stub_q = 16'h1111;
        stub_r = 16'h2222;
        accept(16'd9);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.root !== 16'h1111 || bus.rem !== 16'h2222) begin
            miscompares++;
            $display("FAIL capture_next: got done %b %h %h expected 1 1111 2222", bus.done, bus.root, bus.rem);
        end
        use_stub = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.data_in = '0;
        reset       = 1'b1;
        test_reset();
        test_single();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_capture_isolation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
